// File: rtl/sid_pkg.sv
// Shared definitions for the programmable step sequencer: FSM states,
// register-port byte offsets, ctrl field positions and the pattern word layout.
package sid_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD     = 2'd1,
      GATE_ON  = 2'd2,
      GATE_OFF = 2'd3
   } seq_state_t;

   localparam int NUM_STEPS = 16;

   localparam logic [1:0] FREQ_LO = 2'd0;
   localparam logic [1:0] FREQ_HI = 2'd1;
   localparam logic [1:0] CTRL    = 2'd2;

   localparam int CTRL_WAVE_MSB = 7;
   localparam int CTRL_WAVE_LSB = 4;
   localparam int CTRL_REST     = 3;
   localparam int CTRL_LEN_MSB  = 2;

   typedef struct packed {
      logic [15:0] freq;
      logic [7:0]  ctrl;
   } step_word_t;

endpackage

// File: rtl/seq_tick_gen.sv
// Tick prescaler: counts 0..TICK_DIV-1 while run is high and pulses tick on
// the terminal count; clear has priority and returns the count to zero.
module seq_tick_gen #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic tick
);

   localparam logic [15:0] TERM = 16'(TICK_DIV - 1);

   logic [15:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (run) begin
         if (cnt == TERM) cnt <= '0;
         else             cnt <= cnt + 16'd1;
      end
   end

   assign tick = run && (cnt == TERM);

endmodule

// File: rtl/sid_step_sequencer.sv
// 16-step note sequencer: byte-wide pattern RAM written by the register
// decoder, played back at a programmable tempo to drive sid_voice.
module sid_step_sequencer
   import sid_pkg::*;
#(
   parameter int TICK_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        wr_en,
   input  logic [5:0]  wr_addr,
   input  logic [7:0]  wr_data,
   input  logic [7:0]  tempo,
   input  logic [3:0]  last_step,
   input  logic [7:0]  cfg_duration,
   input  logic [7:0]  cfg_attack,
   input  logic [7:0]  cfg_sustain,
   output logic [15:0] frequency,
   output logic [7:0]  duration,
   output logic [7:0]  attack,
   output logic [7:0]  sustain,
   output logic [7:0]  waveform,
   output logic [3:0]  step_idx,
   output logic        step_strobe
);

   step_word_t ram [NUM_STEPS];
   step_word_t cur_word;

   seq_state_t state, state_nxt;
   logic [3:0] step_nxt;
   logic [7:0] tick_cnt;
   logic [8:0] cnt_inc;
   logic [2:0] cur_len;
   logic [3:0] gate_len;
   logic [7:0] eff_tempo;
   logic [7:0] gate_lim;
   logic [3:0] wave_sel;
   logic       gate;
   logic       tick;
   logic       gate_done;
   logic       step_done;

   seq_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .run   (state != IDLE),
      .clear (state == LOAD),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_STEPS; i++) ram[i] <= '0;
      end else if (wr_en) begin
         case (wr_addr[1:0])
            FREQ_LO: ram[wr_addr[5:2]].freq[7:0]  <= wr_data;
            FREQ_HI: ram[wr_addr[5:2]].freq[15:8] <= wr_data;
            CTRL:    ram[wr_addr[5:2]].ctrl       <= wr_data;
            default: ;
         endcase
      end
   end

   // Read happens before this edge's write lands, so a colliding LOAD sees old data.
   assign cur_word  = ram[step_idx];
   assign eff_tempo = (tempo == 8'd0) ? 8'd1 : tempo;
   assign gate_len  = {1'b0, cur_len} + 4'd1;
   assign gate_lim  = ({4'd0, gate_len} < eff_tempo) ? {4'd0, gate_len} : eff_tempo;
   assign cnt_inc   = {1'b0, tick_cnt} + 9'd1;
   assign gate_done = cnt_inc >= {1'b0, gate_lim};
   assign step_done = cnt_inc >= {1'b0, eff_tempo};

   always_comb begin
      state_nxt = state;
      step_nxt  = step_idx;
      case (state)
         IDLE: if (enable) state_nxt = LOAD;
         LOAD: state_nxt = cur_word.ctrl[CTRL_REST] ? GATE_OFF : GATE_ON;
         GATE_ON: begin
            // A gate clipped by tempo ends the step directly so the retrigger gap is one cycle.
            if (tick && gate_done) begin
               if (step_done) begin
                  state_nxt = LOAD;
                  step_nxt  = (step_idx >= last_step) ? 4'd0 : step_idx + 4'd1;
               end else begin
                  state_nxt = GATE_OFF;
               end
            end
         end
         GATE_OFF: begin
            if (tick && step_done) begin
               state_nxt = LOAD;
               step_nxt  = (step_idx >= last_step) ? 4'd0 : step_idx + 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (!enable) begin
         state_nxt = IDLE;
         step_nxt  = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         step_idx    <= '0;
         tick_cnt    <= '0;
         cur_len     <= '0;
         frequency   <= '0;
         wave_sel    <= '0;
         gate        <= 1'b0;
         step_strobe <= 1'b0;
      end else begin
         state       <= state_nxt;
         step_idx    <= step_nxt;
         step_strobe <= 1'b0;
         if (state == LOAD && enable) begin
            frequency   <= cur_word.freq;
            wave_sel    <= cur_word.ctrl[CTRL_WAVE_MSB:CTRL_WAVE_LSB];
            cur_len     <= cur_word.ctrl[CTRL_LEN_MSB:0];
            gate        <= ~cur_word.ctrl[CTRL_REST];
            step_strobe <= 1'b1;
            tick_cnt    <= '0;
         end else if (tick && (state == GATE_ON || state == GATE_OFF)) begin
            tick_cnt <= tick_cnt + 8'd1;
         end
         if (!enable || (state == GATE_ON && tick && gate_done)) gate <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         duration <= '0;
         attack   <= '0;
         sustain  <= '0;
      end else begin
         duration <= cfg_duration;
         attack   <= cfg_attack;
         sustain  <= cfg_sustain;
      end
   end

   assign waveform = {wave_sel, 3'b000, gate};

endmodule

// File: tb/tb_sid_step_sequencer.sv
// Bench for sid_step_sequencer: phase-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_sid_step_sequencer;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        wr_en = 1'b0;
   logic [5:0]  wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic [7:0]  tempo = '0;
   logic [3:0]  last_step = '0;
   logic [7:0]  cfg_duration = '0;
   logic [7:0]  cfg_attack = '0;
   logic [7:0]  cfg_sustain = '0;
   logic [15:0] frequency;
   logic [7:0]  duration, attack, sustain, waveform;
   logic [3:0]  step_idx;
   logic        step_strobe;

   int checks = 0;
   int errors = 0;

   sid_step_sequencer #(.TICK_DIV(TD)) dut (
      .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .tempo(tempo), .last_step(last_step),
      .cfg_duration(cfg_duration), .cfg_attack(cfg_attack), .cfg_sustain(cfg_sustain),
      .frequency(frequency), .duration(duration), .attack(attack), .sustain(sustain),
      .waveform(waveform), .step_idx(step_idx), .step_strobe(step_strobe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: position within a step is a phase count from the LOAD cycle.
   logic [15:0] m_freq [16];
   logic [7:0]  m_ctrl [16];
   logic [15:0] e_freq;
   logic [3:0]  e_wave, e_step;
   logic        e_gate, e_strobe;
   logic [7:0]  e_dur, e_att, e_sus;
   bit          running = 0;
   bit          chk_on = 0;
   int          ph = 0;
   int          cur_len = 1;

   always @(posedge clk) begin
      int eff, glim;
      eff = (tempo == 0) ? 1 : int'(tempo);
      if (rst) begin
         for (int i = 0; i < 16; i++) begin m_freq[i] = '0; m_ctrl[i] = '0; end
         e_freq = '0; e_wave = '0; e_step = '0; e_gate = 0; e_strobe = 0;
         running = 0; ph = 0; chk_on = 1;
      end else begin
         if (!enable) begin
            running = 0; e_step = '0; e_gate = 0; e_strobe = 0;
         end else if (!running) begin
            running = 1; ph = 0; e_strobe = 0;
         end else begin
            ph++;
            if (ph == eff * TD + 1) begin
               ph = 0; e_gate = 0; e_strobe = 0;
               e_step = (e_step >= last_step) ? 4'd0 : e_step + 4'd1;
            end else if (ph == 1) begin
               e_freq   = m_freq[e_step];
               e_wave   = m_ctrl[e_step][7:4];
               e_gate   = !m_ctrl[e_step][3];
               cur_len  = int'(m_ctrl[e_step][2:0]) + 1;
               e_strobe = 1;
            end else begin
               e_strobe = 0;
               glim = (cur_len < eff) ? cur_len : eff;
               if (ph == glim * TD + 1) e_gate = 0;
            end
         end
         if (wr_en) begin
            case (wr_addr[1:0])
               2'd0: m_freq[wr_addr[5:2]][7:0]  = wr_data;
               2'd1: m_freq[wr_addr[5:2]][15:8] = wr_data;
               2'd2: m_ctrl[wr_addr[5:2]]       = wr_data;
               default: ;
            endcase
         end
      end
      e_dur = rst ? 8'd0 : cfg_duration;
      e_att = rst ? 8'd0 : cfg_attack;
      e_sus = rst ? 8'd0 : cfg_sustain;
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_frequency", 32'(frequency), 32'(e_freq));
         chk("model_waveform", 32'(waveform), 32'({e_wave, 3'b000, e_gate}));
         chk("model_step_idx", 32'(step_idx), 32'(e_step));
         chk("model_step_strobe", 32'(step_strobe), 32'(e_strobe));
         chk("model_duration", 32'(duration), 32'(e_dur));
         chk("model_attack", 32'(attack), 32'(e_att));
         chk("model_sustain", 32'(sustain), 32'(e_sus));
      end
   end

   task automatic wr(input logic [3:0] s, input logic [1:0] b, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = {s, b}; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wr_step(input logic [3:0] s, input logic [15:0] f, input logic [7:0] c);
      wr(s, 2'd0, f[7:0]);
      wr(s, 2'd1, f[15:8]);
      wr(s, 2'd2, c);
   endtask

   task automatic wait_strobe(input string name, input int lim);
      bit ok;
      ok = 0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (step_strobe) begin ok = 1; break; end
      end
      if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_step(input string name, input logic [3:0] s);
      for (int k = 0; k < 8; k++) begin
         wait_strobe(name, 60);
         if (step_idx == s) break;
      end
   endtask

   // Called on a strobe cycle: counts leading gate-high cycles, total low cycles
   // and the distance to the next strobe.
   task automatic measure(input string name, output int hi, output int lo, output int per);
      bit seen_low;
      seen_low = !waveform[0];
      hi = waveform[0] ? 1 : 0;
      lo = waveform[0] ? 0 : 1;
      per = 0;
      for (int i = 1; i < 200; i++) begin
         @(negedge clk);
         if (step_strobe) begin per = i; break; end
         if (!seen_low && waveform[0]) hi++;
         else seen_low = 1;
         if (!waveform[0]) lo++;
      end
      if (per == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int hi, lo, per;
      int exp_idx [5] = '{0, 1, 2, 0, 1};
      logic [15:0] exp_f [5] = '{16'h1234, 16'h0456, 16'h0789, 16'h1234, 16'h0456};

      // Reset and single step
      repeat (3) @(negedge clk);
      chk("rst_frequency", 32'(frequency), 32'h0);
      chk("rst_waveform", 32'(waveform), 32'h0);
      chk("rst_step_idx", 32'(step_idx), 32'h0);
      chk("rst_strobe", 32'(step_strobe), 32'h0);
      rst = 1'b0;
      cfg_duration = 8'h11; cfg_attack = 8'h22; cfg_sustain = 8'h33;
      wr_step(4'd0, 16'h1234, 8'h21);
      tempo = 8'd4; last_step = 4'd0;
      enable = 1'b1;
      @(negedge clk);
      chk("load_no_strobe", 32'(step_strobe), 32'h0);
      @(negedge clk);
      chk("first_frequency", 32'(frequency), 32'h1234);
      chk("first_waveform", 32'(waveform), 32'h21);
      chk("first_strobe", 32'(step_strobe), 32'h1);
      chk("cfg_duration", 32'(duration), 32'h11);
      measure("single", hi, lo, per);
      chk("single_gate_high", 32'(hi), 32'd8);
      chk("single_period", 32'(per), 32'd17);
      chk("single_step_idx", 32'(step_idx), 32'd0);
      enable = 1'b0;
      repeat (2) @(negedge clk);

      // Wrap over three steps
      wr_step(4'd1, 16'h0456, 8'h10);
      wr_step(4'd2, 16'h0789, 8'h33);
      tempo = 8'd2; last_step = 4'd2;
      enable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_strobe("wrap", 30);
         chk($sformatf("wrap_idx%0d", k), 32'(step_idx), 32'(exp_idx[k]));
         chk($sformatf("wrap_freq%0d", k), 32'(frequency), 32'(exp_f[k]));
      end
      enable = 1'b0;
      repeat (2) @(negedge clk);

      // Rest step and gate clipped by tempo
      wr(4'd1, 2'd2, 8'h48);
      wr(4'd2, 2'd2, 8'h47);
      tempo = 8'd3;
      enable = 1'b1;
      wait_strobe("clip_start", 10);
      measure("clip_step0", hi, lo, per);
      chk("clip_step0_hi", 32'(hi), 32'd8);
      chk("clip_step0_per", 32'(per), 32'd13);
      chk("rest_waveform", 32'(waveform), 32'h40);
      measure("rest", hi, lo, per);
      chk("rest_gate_high", 32'(hi), 32'd0);
      chk("rest_per", 32'(per), 32'd13);
      measure("clip", hi, lo, per);
      chk("clip_low_cycles", 32'(lo), 32'd1);
      chk("clip_hi", 32'(hi), 32'd12);

      // Write collision with step1 LOAD
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (step_idx == 4'd1) break;
      end
      wr(4'd1, 2'd0, 8'hAA);
      chk("collide_strobe", 32'(step_strobe), 32'h1);
      chk("collide_old_freq", 32'(frequency), 32'h0456);
      wait_step("collide_revisit", 4'd1);
      chk("collide_new_freq", 32'(frequency), 32'h04AA);

      // Stop mid-step, then lower last_step below the current step
      wait_step("stop", 4'd0);
      enable = 1'b0;
      @(negedge clk);
      chk("stop_waveform", 32'(waveform), 32'h20);
      chk("stop_step_idx", 32'(step_idx), 32'd0);
      chk("stop_freq_hold", 32'(frequency), 32'h1234);
      wr_step(4'd3, 16'h0ABC, 8'h10);
      tempo = 8'd2; last_step = 4'd3;
      enable = 1'b1;
      wait_step("reach3", 4'd3);
      chk("step3_freq", 32'(frequency), 32'h0ABC);
      last_step = 4'd1;
      wait_strobe("lowered", 30);
      chk("lowered_step_idx", 32'(step_idx), 32'd0);
      chk("lowered_freq", 32'(frequency), 32'h1234);

      // tempo 0 acts as 1, then reset mid-pattern
      enable = 1'b0;
      @(negedge clk);
      tempo = 8'd0; last_step = 4'd0;
      enable = 1'b1;
      wait_strobe("t0", 10);
      measure("t0", hi, lo, per);
      chk("t0_hi", 32'(hi), 32'd4);
      chk("t0_per", 32'(per), 32'd5);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_frequency", 32'(frequency), 32'h0);
      chk("midrst_waveform", 32'(waveform), 32'h0);
      chk("midrst_step_idx", 32'(step_idx), 32'h0);
      chk("midrst_duration", 32'(duration), 32'h0);
      chk("midrst_sustain", 32'(sustain), 32'h0);
      rst = 1'b0;
      wait_strobe("restart", 10);
      chk("restart_frequency", 32'(frequency), 32'h0);
      chk("restart_waveform", 32'(waveform), 32'h01);
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
